// File: rtl/pipe_select_mux.sv
// Registered N:1 selector with valid/ready handshake and a one-entry skid buffer.
// Optional saturating out-of-range select counter: define PIPE_SELECT_MUX_ERR_CNT_EN.
//
//   state | meaning
//   EMPTY | MAIN and SKID invalid; in_ready=1, out_valid=0
//   ONE   | MAIN valid, SKID invalid; in_ready=1, out_valid=1
//   FULL  | MAIN and SKID valid; in_ready=0, out_valid=1
// The state is carried by {r_main_vld, r_skid_vld}.
module pipe_select_mux #(
  parameter int               WIDTH     = 16,
  parameter int               NUM_IN    = 3,
  parameter int               SEL_W     = 2,
  parameter logic [WIDTH-1:0] ERR_VALUE = '0
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    flush,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_sel_err,
  output logic                    out_valid,
  input  logic                    out_ready
`ifdef PIPE_SELECT_MUX_ERR_CNT_EN
  ,output logic [15:0]            err_count
`endif
);

  generate
    if (NUM_IN < 2 || NUM_IN > (1 << SEL_W)) begin : g_param_check
      $error("pipe_select_mux: NUM_IN must be in 2..2**SEL_W");
    end
  endgenerate

  logic             r_main_vld;
  logic             r_skid_vld;
  logic             r_in_ready;
  logic [WIDTH-1:0] r_main_data;
  logic             r_main_err;
  logic [WIDTH-1:0] r_skid_data;
  logic             r_skid_err;

  logic             w_accept;
  logic             w_drain;
  logic             w_skid_vld_nxt;
  logic [WIDTH-1:0] w_sel_data;
  logic             w_sel_err;

  // Any select that matches no input falls through to ERR_VALUE with err set.
  always_comb begin
    w_sel_data = ERR_VALUE;
    w_sel_err  = 1'b1;
    for (int k = 0; k < NUM_IN; k++) begin
      if (in_sel == SEL_W'(k)) begin
        w_sel_data = in_data[k*WIDTH +: WIDTH];
        w_sel_err  = 1'b0;
      end
    end
  end

  assign w_accept = in_valid && r_in_ready;
  assign w_drain  = r_main_vld && out_ready;

  // SKID is occupied next cycle if it stays undrained, or ONE takes a beat without draining.
  assign w_skid_vld_nxt = r_skid_vld ? !w_drain : (r_main_vld && w_accept && !w_drain);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_main_vld  <= 1'b0;
      r_skid_vld  <= 1'b0;
      r_in_ready  <= 1'b0;
      r_main_data <= '0;
      r_main_err  <= 1'b0;
      r_skid_data <= '0;
      r_skid_err  <= 1'b0;
    end else if (flush) begin
      r_main_vld  <= 1'b0;
      r_skid_vld  <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      r_in_ready <= !w_skid_vld_nxt;
      if (r_skid_vld) begin
        if (w_drain) begin
          r_main_data <= r_skid_data;
          r_main_err  <= r_skid_err;
          r_skid_vld  <= 1'b0;
        end
      end else if (r_main_vld) begin
        if (w_accept && w_drain) begin
          r_main_data <= w_sel_data;
          r_main_err  <= w_sel_err;
        end else if (w_accept) begin
          r_skid_data <= w_sel_data;
          r_skid_err  <= w_sel_err;
          r_skid_vld  <= 1'b1;
        end else if (w_drain) begin
          r_main_vld  <= 1'b0;
        end
      end else if (w_accept) begin
        r_main_data <= w_sel_data;
        r_main_err  <= w_sel_err;
        r_main_vld  <= 1'b1;
      end
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = r_main_vld;
  assign out_data    = r_main_data;
  assign out_sel_err = r_main_err;

`ifdef PIPE_SELECT_MUX_ERR_CNT_EN
  logic [15:0] r_err_cnt;

  // A handshake counts even in a flush cycle; only reset clears the count.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_err_cnt <= '0;
    end else if (w_accept && w_sel_err && r_err_cnt != 16'hFFFF) begin
      r_err_cnt <= r_err_cnt + 16'd1;
    end
  end

  assign err_count = r_err_cnt;
`endif

endmodule

// File: tb/tb_pipe_select_mux.sv
// Self-checking bench for pipe_select_mux: queue-based reference model checked every
// cycle, plus directed literal expectations and a randomized 1000-beat run.
module tb_pipe_select_mux;
  localparam int W  = 16;
  localparam int N  = 3;
  localparam int SW = 2;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic [N*W-1:0] in_data = '0;
  logic [SW-1:0]  in_sel = '0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic           flush = 1'b0;
  logic [W-1:0]   out_data;
  logic           out_sel_err;
  logic           out_valid;
  logic           out_ready = 1'b0;
`ifdef PIPE_SELECT_MUX_ERR_CNT_EN
  logic [15:0]    err_count;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipe_select_mux #(.WIDTH(W), .NUM_IN(N), .SEL_W(SW), .ERR_VALUE('0)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .flush      (flush),
    .out_data   (out_data),
    .out_sel_err(out_sel_err),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
`ifdef PIPE_SELECT_MUX_ERR_CNT_EN
    ,.err_count (err_count)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: held beats are a FIFO of at most two {err,data} entries.
  logic [16:0] q[$];
  bit          m_rdy   = 1'b0;
  bit          started = 1'b0;
  int          acc_cnt = 0;
  int          m_errs  = 0;

  always @(posedge clk) begin : model
    bit          drain;
    bit          acc;
    logic [16:0] beat;
    started = 1'b1;
    beat    = '0;
    if (!reset_n) begin
      q.delete();
      m_rdy  = 1'b0;
      m_errs = 0;
    end else begin
      drain = (q.size() > 0) && out_ready;
      acc   = in_valid && m_rdy;
      if (acc) begin
        if (int'(in_sel) < N) beat = {1'b0, in_data[int'(in_sel)*W +: W]};
        else                  beat = {1'b1, 16'h0000};
        if (beat[16] && m_errs < 65535) m_errs++;
        acc_cnt++;
      end
      if (flush) begin
        q.delete();
        m_rdy = 1'b1;
      end else begin
        if (drain) void'(q.pop_front());
        if (acc) q.push_back(beat);
        m_rdy = (q.size() < 2);
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("cyc_out_valid", 32'(out_valid), 32'(q.size() > 0));
      check("cyc_in_ready", 32'(in_ready), 32'(m_rdy));
      if (q.size() > 0) begin
        check("cyc_out_data", 32'(out_data), 32'(q[0][15:0]));
        check("cyc_out_sel_err", 32'(out_sel_err), 32'(q[0][16]));
      end
`ifdef PIPE_SELECT_MUX_ERR_CNT_EN
      check("cyc_err_count", 32'(err_count), 32'(m_errs));
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cyc;
    int base;

    // Reset
    step();
    step();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    reset_n = 1'b1;
    step();
    check("rst_release_in_ready", 32'(in_ready), 32'd1);

    // Consecutive selects 0/1/2
    in_data   = {16'h3333, 16'h2222, 16'h1111};
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_sel    = 2'd0;
    step();
    check("sel0_data", 32'(out_data), 32'h1111);
    in_sel = 2'd1;
    step();
    check("sel1_data", 32'(out_data), 32'h2222);
    in_sel = 2'd2;
    step();
    check("sel2_data", 32'(out_data), 32'h3333);
    check("sel2_err", 32'(out_sel_err), 32'd0);
    check("sel2_valid", 32'(out_valid), 32'd1);

    // Out-of-range select
    in_data[15:0] = 16'hABCD;
    in_sel        = 2'd3;
    step();
    check("oor_data", 32'(out_data), 32'h0000);
    check("oor_err", 32'(out_sel_err), 32'd1);
`ifdef PIPE_SELECT_MUX_ERR_CNT_EN
    check("oor_err_count", 32'(err_count), 32'd1);
`endif
    in_valid = 1'b0;
    step();

    // Back-pressure: A to MAIN, B to SKID, C held upstream
    out_ready     = 1'b0;
    in_valid      = 1'b1;
    in_sel        = 2'd0;
    in_data[15:0] = 16'hAAAA;
    step();
    check("bp_a_data", 32'(out_data), 32'hAAAA);
    in_data[15:0] = 16'hBBBB;
    step();
    check("bp_full_in_ready", 32'(in_ready), 32'd0);
    in_data[15:0] = 16'hCCCC;
    step();
    step();
    check("bp_hold_data", 32'(out_data), 32'hAAAA);
    out_ready = 1'b1;
    step();
    check("bp_b_data", 32'(out_data), 32'hBBBB);
    check("bp_b_in_ready", 32'(in_ready), 32'd1);
    step();
    check("bp_c_data", 32'(out_data), 32'hCCCC);
    in_valid = 1'b0;
    step();
    check("bp_drained", 32'(out_valid), 32'd0);

    // Randomized 1000 beats
    base = acc_cnt;
    cyc  = 0;
    while (acc_cnt < base + 1000 && cyc < 20000) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_sel    = 2'($urandom_range(0, 3));
      in_data   = 48'({$urandom, $urandom});
      out_ready = 1'($urandom_range(0, 1));
      step();
      cyc++;
    end
    total++;
    if (acc_cnt < base + 1000) begin
      bad++;
      $display("FAIL rand_timeout accepted=%0d required=%0d", acc_cnt - base, 1000);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    step();
    step();
    check("rand_drained", 32'(out_valid), 32'd0);

    // Flush from FULL with a beat offered in the flush cycle
    out_ready     = 1'b0;
    in_valid      = 1'b1;
    in_sel        = 2'd0;
    in_data[15:0] = 16'h5555;
    step();
    in_data[15:0] = 16'h6666;
    step();
    check("fl_full_in_ready", 32'(in_ready), 32'd0);
    flush         = 1'b1;
    in_data[15:0] = 16'h7777;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("fl_out_valid", 32'(out_valid), 32'd0);
    check("fl_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    step();
    step();
    check("fl_nothing_out", 32'(out_valid), 32'd0);

    // Reset with one beat held in MAIN
    out_ready     = 1'b0;
    in_valid      = 1'b1;
    in_data[15:0] = 16'h9999;
    step();
    in_valid = 1'b0;
    check("mr_held", 32'(out_data), 32'h9999);
    reset_n = 1'b0;
    step();
    check("mr_out_valid", 32'(out_valid), 32'd0);
    check("mr_out_data", 32'(out_data), 32'd0);
    check("mr_in_ready", 32'(in_ready), 32'd0);
    reset_n = 1'b1;
    step();
    check("mr_in_ready_rise", 32'(in_ready), 32'd1);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_select_mux.md
Name: pipe_select_mux

Overview:
- Parametrised, registered N:1 selector with a valid/ready handshake and a one-entry skid buffer.
- Successor to the combinational operand/writeback selectors in the 16-bit datapath.
- Placed between pipeline stages, for example ALU-operand or writeback-source select, where selection must be registered and back-pressure must be absorbed without a combinational ready path.
- Handles out-of-range selects deterministically instead of driving X.

Parameters:
- WIDTH, 16, data width of each input and of the output.
- NUM_IN, 3, number of data inputs; legal range 2..2**SEL_W.
- SEL_W, 2, select width; NUM_IN <= 2**SEL_W is required, and elaboration is rejected otherwise.
- ERR_VALUE, 0, WIDTH-bit value driven as data when the select is out of range.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  synchronous, active-low reset.
- in_data  input  NUM_IN*WIDTH  flattened inputs; input k occupies bits [k*WIDTH +: WIDTH].
- in_sel  input  SEL_W  index of the input to forward.
- in_valid  input  1  in_data/in_sel are valid this cycle.
- in_ready  output  1  block accepts a beat this cycle; driven from a register.
- flush  input  1  synchronous discard of all held beats.
- out_data  output  WIDTH  selected data.
- out_sel_err  output  1  beat was produced from an out-of-range select.
- out_valid  output  1  out_data/out_sel_err are valid.
- out_ready  input  1  downstream accepts the beat.

Behaviour:
- Transfer rules:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
- Select resolution at input transfer:
  - If in_sel < NUM_IN: data is in_data[in_sel*WIDTH +: WIDTH] and err = 0.
  - Otherwise: data is ERR_VALUE and err = 1.
- Storage: two registers, MAIN (drives the outputs) and SKID, each holding {data, err, valid}.
- Latency: a beat accepted in cycle t appears on out_* in cycle t+1 when MAIN is empty or is draining in cycle t.
- State machine (encoded by the MAIN/SKID valid bits):
  - EMPTY:
    - in_ready = 1, out_valid = 0.
    - On accept: load MAIN, go to ONE.
  - ONE:
    - out_valid = 1, in_ready = 1.
    - Accept and drain: load MAIN, stay in ONE.
    - Accept only: load SKID, go to FULL.
    - Drain only: go to EMPTY.
    - Neither: hold.
  - FULL:
    - out_valid = 1, in_ready = 0.
    - On drain: SKID moves to MAIN, go to ONE.
    - Inputs are ignored in this state.
- in_ready is registered; it is the inverse of the next-state SKID valid bit.
- No combinational path runs from out_ready to in_ready, and none from in_* to out_*.
- While out_valid = 1 and out_ready = 0, out_data and out_sel_err hold stable.
- flush:
  - Next cycle: MAIN and SKID are invalid, out_valid = 0, in_ready = 1.
  - Any input beat presented in the flush cycle is discarded.
  - An output transfer in the flush cycle still counts as completed.
  - flush has priority over every other event.
- reset_n = 0 at a clock edge:
  - out_valid = 0, out_data = 0, out_sel_err = 0, in_ready = 0, SKID cleared.
  - in_ready rises to 1 on the first edge with reset_n = 1.
  - Reset mid-transfer drops all held beats.
- The select path is WIDTH bits wide; no arithmetic is involved.
- in_sel is sampled only at input transfer.
- An X on an unsampled in_sel must not propagate.

Optional Feature:
- Macro: PIPE_SELECT_MUX_ERR_CNT_EN.
- When defined:
  - Adds output port err_count [15:0].
  - err_count increments on every input transfer with an out-of-range select.
  - It saturates at 16'hFFFF and clears on reset only; flush does not clear it.
- When undefined: the port and counter are absent, and the block is otherwise identical.

Test Plan:
(All scenarios use WIDTH = 16, NUM_IN = 3, SEL_W = 2, ERR_VALUE = 0.)
- Reset, then idle with out_ready = 1, inputs {16'h1111, 16'h2222, 16'h3333}:
  - in_sel = 0/1/2 on consecutive valid cycles produces out_data 1111/2222/3333 on cycles t+1..t+3.
  - out_valid stays high throughout and out_sel_err = 0.
- in_sel = 3, in_data[0] = 16'hABCD, in_valid = 1:
  - Next cycle: out_data = 16'h0000 and out_sel_err = 1.
  - With the macro defined, err_count = 1.
- out_ready = 0 while 3 beats (A, B, C) are offered back-to-back:
  - A is accepted to MAIN and B to SKID; in_ready drops after B; C is held upstream.
  - out_data stays A until out_ready = 1.
  - Output order is then A, B, C with no loss or duplication.
- Random out_ready (50%) and random in_valid over 1000 beats: output sequence equals the reference-selected input sequence.
- With FULL (two beats held), assert flush for one cycle with in_valid = 1:
  - Next cycle: out_valid = 0 and in_ready = 1.
  - Neither the held beats nor the flush-cycle beat ever appear on the output.
- With one beat in MAIN and out_ready = 0, assert reset_n = 0 for one cycle:
  - Next cycle: out_valid = 0, out_data = 0, in_ready = 0.
  - The following cycle in_ready = 1.
